// File: rtl/testador_pkg.sv
// Shared definitions for the gate tester: op codes, FSM encoding, vector count.
package testador_pkg;

   // Number of input vectors applied per run (a/b = 00, 01, 10, 11).
   localparam int NUM_VEC = 4;

   // Expected-gate selector; 110 and 111 are not assigned and mark an invalid run.
   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_NAND = 3'b010,
      OP_NOR  = 3'b011,
      OP_XOR  = 3'b100,
      OP_XNOR = 3'b101
   } op_e;

   // Tester sequencing states.
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      APPLY    = 3'd1,
      SETTLE_W = 3'd2,
      SAMPLE   = 3'd3,
      DONE     = 3'd4
   } state_e;

   // True when the op code names one of the six supported gates.
   function automatic logic op_valid(input logic [2:0] op_i);
      return (op_i <= 3'b101);
   endfunction

endpackage

// File: rtl/testador_porta_ref.sv
// Reference gate: expected response for the captured op and the applied a/b.
module porta_ref
   import testador_pkg::*;
(
   input  logic [2:0] op,
   input  logic       a,
   input  logic       b,
   output logic       y_esp
);

   // Evaluate the selected two-input gate; unassigned codes yield 0.
   always_comb begin
      y_esp = 1'b0;
      case (op)
         OP_AND:  y_esp = a & b;
         OP_OR:   y_esp = a | b;
         OP_NAND: y_esp = ~(a & b);
         OP_NOR:  y_esp = ~(a | b);
         OP_XOR:  y_esp = a ^ b;
         OP_XNOR: y_esp = ~(a ^ b);
         default: y_esp = 1'b0;
      endcase
   end

endmodule

// File: rtl/testador_porta.sv
// Two-input gate tester: walks the four a/b vectors, lets the DUT settle,
// samples y against a reference gate and reports pass, error count and mask.
module testador_porta
   import testador_pkg::*;
#(
   parameter int SETTLE = 2
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] op,
   output logic       a,
   output logic       b,
   input  logic       y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] err_mask
);

   // Last value of the settle counter before moving to SAMPLE.
   localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
   localparam logic       SKIP_SETTLE = (SETTLE == 0);
   localparam logic [1:0] IDX_LAST    = 2'(NUM_VEC - 1);

   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] op_q, op_d;
   logic       hold_q, hold_d;
   logic       a_q, a_d;
   logic       b_q, b_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [2:0] err_count_q, err_count_d;
   logic [3:0] err_mask_q, err_mask_d;
   logic [1:0] idx_nxt_s;
   logic       y_esp_s;

   assign idx_nxt_s = idx_q + 2'd1;

   porta_ref u_ref (
      .op    (op_q),
      .a     (a_q),
      .b     (b_q),
      .y_esp (y_esp_s)
   );

   // Next-state and next-output computation for the tester sequence.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      hold_d      = hold_q;
      a_d         = a_q;
      b_d         = b_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      pass_d      = pass_q;
      err_count_d = err_count_q;
      err_mask_d  = err_mask_q;

      case (state_q)
         IDLE: begin
            a_d   = 1'b0;
            b_d   = 1'b0;
            idx_d = 2'd0;
            cnt_d = 4'd0;
            if (start) begin
               op_d   = op;
               busy_d = 1'b1;
               pass_d = 1'b0;
               if (op_valid(op)) begin
                  // Vector 0 (a=0, b=0) goes out on the accepting edge.
                  err_count_d = 3'd0;
                  err_mask_d  = 4'b0000;
                  hold_d      = 1'b0;
                  state_d     = APPLY;
               end else begin
                  // Invalid op: every vector counts as failed, nothing is applied,
                  // and the verdict is posted after one extra DONE cycle.
                  err_count_d = 3'd4;
                  err_mask_d  = 4'b1111;
                  hold_d      = 1'b1;
                  state_d     = DONE;
               end
            end else begin
               state_d = IDLE;
            end
         end

         APPLY: begin
            cnt_d = 4'd0;
            if (SKIP_SETTLE) begin
               state_d = SAMPLE;
            end else begin
               state_d = SETTLE_W;
            end
         end

         SETTLE_W: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = 4'd0;
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end

         SAMPLE: begin
            if (y != y_esp_s) begin
               err_count_d       = err_count_q + 3'd1;
               err_mask_d[idx_q] = 1'b1;
            end else begin
               err_count_d = err_count_q;
            end
            if (idx_q == IDX_LAST) begin
               a_d     = 1'b0;
               b_d     = 1'b0;
               hold_d  = 1'b0;
               state_d = DONE;
            end else begin
               idx_d   = idx_nxt_s;
               a_d     = idx_nxt_s[1];
               b_d     = idx_nxt_s[0];
               state_d = APPLY;
            end
         end

         DONE: begin
            a_d = 1'b0;
            b_d = 1'b0;
            if (hold_q) begin
               hold_d = 1'b0;
            end else begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_count_q == 3'd0) && op_valid(op_q);
               idx_d   = 2'd0;
               state_d = IDLE;
            end
         end

         default: begin
            a_d     = 1'b0;
            b_d     = 1'b0;
            busy_d  = 1'b0;
            hold_d  = 1'b0;
            idx_d   = 2'd0;
            cnt_d   = 4'd0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= 2'd0;
         cnt_q       <= 4'd0;
         op_q        <= 3'b000;
         hold_q      <= 1'b0;
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_count_q <= 3'd0;
         err_mask_q  <= 4'b0000;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         hold_q      <= hold_d;
         a_q         <= a_d;
         b_q         <= b_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_count_q <= err_count_d;
         err_mask_q  <= err_mask_d;
      end
   end

   assign a         = a_q;
   assign b         = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_count_q;
   assign err_mask  = err_mask_q;

endmodule

// File: tb/tb_testador_porta.sv
// Self-checking bench for testador_porta: a structural OR gate (or y tied low)
// acts as the device under test; expected verdicts go through a scoreboard.
module tb_testador_porta;

   localparam int SETTLE    = 2;
   localparam int LAT_VALID = 4 * (SETTLE + 2) + 1;
   localparam int LAT_INV   = 2;

   typedef struct {
      logic       pass;
      logic [2:0] cnt;
      logic [3:0] mask;
      int         cyc;
   } sb_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [2:0] op;
   logic       a;
   logic       b;
   logic       y;
   logic       y_or;
   logic       gate_mode;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_count;
   logic [3:0] err_mask;

   int  n_total = 0;
   int  n_pass  = 0;
   int  n_done  = 0;
   int  cyc     = 0;
   sb_t sb_q[$];

   // Gate under test: structural OR, or output stuck at 0 when gate_mode=1.
   or g_or (y_or, a, b);
   assign y = gate_mode ? 1'b0 : y_or;

   testador_porta #(.SETTLE(SETTLE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .y         (y),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .err_mask  (err_mask)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Rising-edge counter used to time done pulses.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Expected verdict from gate truth tables indexed by vector number {a,b}.
   function automatic sb_t model(input logic [2:0] op_v, input logic mode_v);
      sb_t        r;
      logic [3:0] tt;
      logic [3:0] resp;
      logic       ok;
      ok = 1'b1;
      case (op_v)
         3'd0:    tt = 4'b1000;
         3'd1:    tt = 4'b1110;
         3'd2:    tt = 4'b0111;
         3'd3:    tt = 4'b0001;
         3'd4:    tt = 4'b0110;
         3'd5:    tt = 4'b1001;
         default: begin tt = 4'b0000; ok = 1'b0; end
      endcase
      resp = mode_v ? 4'b0000 : 4'b1110;
      if (ok) begin
         r.mask = resp ^ tt;
         r.cnt  = 3'($countones(r.mask));
         r.pass = (r.mask == 4'b0000);
      end else begin
         r.mask = 4'b1111;
         r.cnt  = 3'd4;
         r.pass = 1'b0;
      end
      r.cyc = 0;
      return r;
   endfunction

   // Scoreboard consumer: every done pulse pops and checks one expected verdict.
   always @(negedge clk) begin
      sb_t e;
      if (done === 1'b1) begin
         n_done++;
         if (sb_q.size() == 0) begin
            chk("done_unexpected", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("pass", pass, e.pass);
            chk("err_count", err_count, e.cnt);
            chk("err_mask", err_mask, e.mask);
         end
      end
   end

   // One run: drive start, push expectation, check each vector cycle and the aftermath.
   task automatic run_vec(input logic [2:0] op_v, input logic mode_v, input bit midrun);
      sb_t  e;
      int   lat;
      int   vi;
      logic valid;
      logic ea;
      logic eb;
      valid     = (op_v <= 3'd5);
      lat       = valid ? LAT_VALID : LAT_INV;
      gate_mode = mode_v;
      @(negedge clk);
      op    = op_v;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e     = model(op_v, mode_v);
      e.cyc = cyc + lat;
      sb_q.push_back(e);
      for (int j = 0; j < lat; j++) begin
         vi = j / (SETTLE + 2);
         ea = valid ? vi[1] : 1'b0;
         eb = valid ? vi[0] : 1'b0;
         chk("a_vec", a, ea);
         chk("b_vec", b, eb);
         chk("busy_run", busy, 1'b1);
         chk("done_early", done, 1'b0);
         if (midrun && j == 6) begin
            start = 1'b1;
            op    = 3'b000;
         end else if (midrun && j == 7) begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      chk("busy_end", busy, 1'b0);
      chk("a_idle", a, 1'b0);
      chk("b_idle", b, 1'b0);
      @(negedge clk);
      chk("done_width", done, 1'b0);
      repeat (2) @(negedge clk);
      chk("pass_hold", pass, e.pass);
      chk("count_hold", err_count, e.cnt);
      chk("mask_hold", err_mask, e.mask);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_a"}, a, 1'b0);
      chk({tag, "_b"}, b, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_pass"}, pass, 1'b0);
      chk({tag, "_cnt"}, err_count, 3'd0);
      chk({tag, "_mask"}, err_mask, 4'b0000);
   endtask

   initial begin
      sb_t e;
      int  c0;
      int  d0;
      rst_n     = 1'b0;
      start     = 1'b0;
      op        = 3'b000;
      gate_mode = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst_n = 1'b1;

      // Main function across gates, stuck output, invalid ops and a mid-run start/op change.
      run_vec(3'b001, 1'b0, 1'b0);
      run_vec(3'b000, 1'b0, 1'b0);
      run_vec(3'b011, 1'b1, 1'b0);
      run_vec(3'b111, 1'b0, 1'b0);
      run_vec(3'b001, 1'b0, 1'b1);
      run_vec(3'b100, 1'b0, 1'b0);
      run_vec(3'b010, 1'b1, 1'b0);
      run_vec(3'b101, 1'b0, 1'b0);
      run_vec(3'b110, 1'b0, 1'b0);

      // Reset during vector 2 aborts the run without a done pulse.
      gate_mode = 1'b0;
      @(negedge clk);
      op    = 3'b001;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("mid_a", a, 1'b1);
      chk("mid_b", b, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_reset_vals("midrst");
      d0 = n_done;
      repeat (25) @(negedge clk);
      chk("midrst_no_done", n_done - d0, 0);
      chk("midrst_idle", busy, 1'b0);
      run_vec(3'b001, 1'b0, 1'b0);

      // Start held high: three back-to-back runs, one IDLE cycle apart.
      gate_mode = 1'b0;
      @(negedge clk);
      op    = 3'b001;
      start = 1'b1;
      @(negedge clk);
      c0 = cyc;
      d0 = n_done;
      e  = model(3'b001, 1'b0);
      for (int k = 0; k < 3; k++) begin
         e.cyc = c0 + LAT_VALID + k * (LAT_VALID + 1);
         sb_q.push_back(e);
      end
      repeat (2 * (LAT_VALID + 1)) @(negedge clk);
      start = 1'b0;
      repeat (LAT_VALID + 4) @(negedge clk);
      chk("b2b_done_count", n_done - d0, 3);
      chk("sb_empty", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
